// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: datapath width, op codes,
// FSM state encoding and a small operand helper.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Two's-complement magnitude when neg is set, pass-through otherwise.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            quot_bit_o
);

    logic [XLEN:0] partial;

    assign partial    = {rem_i, dividend_bit_i};
    assign quot_bit_o = (partial >= {1'b0, divisor_i});
    // The difference is below the divisor, so the low XLEN bits are exact.
    assign rem_o      = quot_bit_o ? (partial[XLEN-1:0] - divisor_i) : partial[XLEN-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers: 32 RUN steps
// on operand magnitudes, then one FIX cycle for sign correction and writeback.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] a_q, a_d;
    logic            is_div_q, is_div_d;
    logic            div0_q, div0_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;

    logic            op_signed, op_div, neg_a_in, neg_b_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] step_rem;
    logic            step_qbit;
    logic [XLEN:0]   sum;
    logic [63:0]     product, product_fix;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign neg_a_in  = op_signed & a[XLEN-1];
    assign neg_b_in  = op_signed & b[XLEN-1];
    assign mag_a     = mag(a, neg_a_in);
    assign mag_b     = mag(b, neg_b_in);

    // For divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    mdu_div_step u_div_step (
        .rem_i          (acc_hi_q),
        .dividend_bit_i (acc_lo_q[XLEN-1]),
        .divisor_i      (mcand_q),
        .rem_o          (step_rem),
        .quot_bit_o     (step_qbit)
    );

    // For multiply: {acc_hi, acc_lo} is the product register with the multiplier in acc_lo.
    assign sum         = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    assign product     = {acc_hi_q, acc_lo_q};
    assign product_fix = (neg_a_q ^ neg_b_q) ? (~product + 64'd1) : product;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = a;
                    is_div_d = op_div;
                    div0_d   = (b == '0);
                    neg_a_d  = neg_a_in;
                    neg_b_d  = neg_b_in;
                    acc_hi_d = '0;
                    acc_lo_d = op_div ? mag_a : mag_b;
                    mcand_d  = op_div ? mag_b : mag_a;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    acc_hi_d = step_rem;
                    acc_lo_d = {acc_lo_q[XLEN-2:0], step_qbit};
                end else begin
                    acc_hi_d = sum[XLEN:1];
                    acc_lo_d = {sum[0], acc_lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (!is_div_q) begin
                    hi_d = product_fix[63:32];
                    lo_d = product_fix[31:0];
                end else if (div0_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    // Quotient sign from both operands; remainder follows the dividend.
                    lo_d = mag(acc_lo_q, neg_a_q ^ neg_b_q);
                    hi_d = mag(acc_hi_q, neg_a_q);
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a new operation, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2: operation code, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a, input, 32: rs operand, taken from the EX forwarding mux output.
REQ-007 SHALL have port b, input, 32: rt operand, taken from the EX forwarding mux output.
REQ-008 SHALL have port hi_we, input, 1: MTHI write enable.
REQ-009 SHALL have port lo_we, input, 1: MTLO write enable.
REQ-010 SHALL have port wdata, input, 32: MTHI/MTLO write data.
REQ-011 SHALL have port busy, output, 1: operation in progress; the hazard unit stalls MFHI/MFLO/MULT/DIV on it.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when a new HI/LO result is visible.
REQ-013 SHALL have port hi, output, 32: HI register.
REQ-014 SHALL have port lo, output, 32: LO register.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and FIX.
REQ-016 SHALL, in IDLE with start=1: latch a, b and op; convert signed operands to magnitudes; clear a 5-bit iteration counter; go to RUN.
REQ-017 SHALL, in RUN, perform one shift-add multiply step or one restoring divide step per cycle for exactly 32 cycles (counter 0..31), then go to FIX.
REQ-018 SHALL, in FIX, apply sign correction, write HI/LO, set done for the next cycle, and return to IDLE.
REQ-019 SHALL drive busy = (state != IDLE), decoded combinationally from state; busy is high for exactly 33 cycles per operation.
REQ-020 SHALL make the result visible on hi/lo with done=1 in the 34th cycle after the edge that sampled start.
REQ-021 SHALL produce the full 64-bit product for MULT/MULTU: HI = upper 32 bits, LO = lower 32 bits; signed product in two's complement.
REQ-022 SHALL produce the quotient in LO and the remainder in HI for DIV/DIVU; the signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-023 SHALL, on divide by zero (both signednesses), run the full 33 busy cycles and produce LO=0xFFFFFFFF, HI=a.
REQ-024 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000, HI=0x00000000.
REQ-025 SHALL ignore start while busy; the in-flight operation is unaffected.
REQ-026 SHALL, in IDLE with start=0, write wdata to HI at the edge when hi_we=1 and to LO when lo_we=1; both may write in the same cycle.
REQ-027 SHALL drop hi_we and lo_we while busy, and also when start=1 in the same IDLE cycle (start has priority).
REQ-028 SHALL keep HI and LO unchanged during RUN; they change only in FIX, via MTHI/MTLO, or on reset.
REQ-029 SHALL hold done low in every cycle except the one following FIX.

Reset
REQ-030 SHALL, while reset=1 at a rising edge, set state=IDLE, counter=0, hi=0, lo=0, done=0 (so busy=0); reset has priority over all inputs.
REQ-031 SHALL, on reset mid-operation, abandon the operation with no done pulse and no HI/LO update; start is accepted in the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the op encodings, the FSM state enum and the XLEN=32 constant in a shared package mdu_pkg.
REQ-033 SHALL use one combinational sub-module, mdu_div_step, for a single restoring-divide iteration (partial remainder, divisor -> next remainder, quotient bit); the multiply step is inline.

Verification
REQ-034 SHALL cover: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, busy high for 33 cycles, done in cycle 34.
REQ-035 SHALL cover: MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 SHALL cover: DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 SHALL cover: start, hi_we and lo_we pulsed at cycle 5 of a busy operation -> all ignored, and the original result is delivered unchanged.
REQ-038 SHALL cover: lo_we with wdata=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5 next cycle; start together with hi_we -> operation runs and HI is not written by wdata.
REQ-039 SHALL cover: reset asserted at RUN cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a new MULTU 6x7 then yields LO=42, HI=0.
